// File: rtl/frame_ctrl_if.sv
// rtl/frame_ctrl_if.sv - memory push/pop handshake between frame_ctrl and the memory interface unit
//
// Signals:
//   mem_req   request, held until mem_ack is sampled
//   mem_we    1 = write (push), 0 = read (pop)
//   mem_addr  access address
//   mem_wdata push data
//   mem_rdata pop data, valid with mem_ack
//   mem_ack   access complete
// Modports: master = frame_ctrl, slave = memory interface unit.
interface frame_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/frame_ctrl.sv
// rtl/frame_ctrl.sv - ENTER (level 0) / LEAVE stack-frame sequencer
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   start_enter, start_leave one-cycle instruction requests from decode
//   frame_size               local-variable bytes, sampled with start_enter
//   sp_in, bp_in             current SP / BP register values
//   mem                      memory handshake (frame_ctrl_if.master)
//   bp_ena, bp_d             BP register load (one cycle, bank loads on falling edge)
//   sp_ena, sp_d             SP register load (one cycle)
//   busy, done, err          status to decode; err pulses with done on ack timeout
// All outputs are registered.
module frame_ctrl #(
    parameter int WIDTH       = 16,
    parameter int WORD_BYTES  = 2,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start_enter,
    input  logic              start_leave,
    input  logic [WIDTH-1:0]  frame_size,
    input  logic [WIDTH-1:0]  sp_in,
    input  logic [WIDTH-1:0]  bp_in,
    frame_ctrl_if.master      mem,
    output logic              bp_ena,
    output logic [WIDTH-1:0]  bp_d,
    output logic              sp_ena,
    output logic [WIDTH-1:0]  sp_d,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] E_PUSH = 3'd1;
    localparam logic [2:0] E_UPD  = 3'd2;
    localparam logic [2:0] L_POP  = 3'd3;
    localparam logic [2:0] L_UPD  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    localparam logic [WIDTH-1:0] WB       = WORD_BYTES[WIDTH-1:0];
    localparam logic [15:0]      TO_LAST  = 16'(ACK_TIMEOUT - 1);

    logic [2:0]       state;
    logic [15:0]      cnt;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] f_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            s_q           <= '0;
            b_q           <= '0;
            f_q           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            bp_ena        <= 1'b0;
            bp_d          <= '0;
            sp_ena        <= 1'b0;
            sp_d          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start_enter) begin
                        s_q           <= sp_in - WB;
                        b_q           <= bp_in;
                        f_q           <= frame_size;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= sp_in - WB;
                        mem.mem_wdata <= bp_in;
                        busy          <= 1'b1;
                        state         <= E_PUSH;
                    end else if (start_leave) begin
                        b_q          <= bp_in;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= bp_in;
                        busy         <= 1'b1;
                        state        <= L_POP;
                    end
                end
                E_PUSH: begin
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        bp_ena      <= 1'b1;
                        bp_d        <= s_q;
                        sp_ena      <= 1'b1;
                        sp_d        <= s_q - f_q;
                        state       <= E_UPD;
                    end else if (cnt == TO_LAST) begin
                        // Abort: skip the register update entirely.
                        mem.mem_req <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                L_POP: begin
                    if (mem.mem_ack) begin
                        // bp_d doubles as the latched pop result R.
                        mem.mem_req <= 1'b0;
                        bp_ena      <= 1'b1;
                        bp_d        <= mem.mem_rdata;
                        sp_ena      <= 1'b1;
                        sp_d        <= b_q + WB;
                        state       <= L_UPD;
                    end else if (cnt == TO_LAST) begin
                        mem.mem_req <= 1'b0;
                        done        <= 1'b1;
                        err         <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                E_UPD, L_UPD: begin
                    bp_ena <= 1'b0;
                    sp_ena <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem.mem_req <= 1'b0;
                    bp_ena      <= 1'b0;
                    sp_ena      <= 1'b0;
                    done        <= 1'b0;
                    err         <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
